// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues imemory requests and queues returned words for decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_RESET = 32'h0100_0000
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [31:0]              imem_addr,
   output logic                     imem_req,
   input  logic [31:0]              imem_data,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

   logic [31:0]   fetch_pc_r;
   logic [31:0]   req_pc_r;
   logic          inflight_r;
   logic [31:0]   inst_mem_r [DEPTH];
   logic [31:0]   pc_mem_r   [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;

   logic [CW:0]   occupancy_s;
   logic          fifo_empty_s;
   logic          issue_s;
   logic          bypass_s;
   logic          push_s;
   logic          pop_s;

   // Issue decision: reserve a slot for the in-flight response; same-cycle pops are not credited.
   always_comb begin
      occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
      fifo_empty_s = (count_r == {CW{1'b0}});
      issue_s      = reset && !redirect && (occupancy_s < DEPTH_LIM);
   end

`ifdef FETCH_BYPASS_EN
   // Bypass is possible only when a response lands in an empty queue.
   always_comb begin
      bypass_s = fifo_empty_s && inflight_r && !redirect;
   end
`else
   // No bypass path in this build.
   always_comb begin
      bypass_s = 1'b0;
   end
`endif

   // Decode-side view of the head entry plus push/pop strobes.
   always_comb begin
      if (bypass_s) begin
         out_valid = 1'b1;
         out_inst  = imem_data;
         out_pc    = req_pc_r;
      end else begin
         out_valid = !fifo_empty_s;
         out_inst  = inst_mem_r[rd_ptr_r];
         out_pc    = pc_mem_r[rd_ptr_r];
      end
      // A bypassed word that decode takes immediately never enters the queue.
      push_s = inflight_r && !redirect && !(bypass_s && out_ready);
      pop_s  = !fifo_empty_s && out_ready;
   end

   // Output wiring of the fetch address and occupancy.
   always_comb begin
      imem_addr = fetch_pc_r;
      imem_req  = issue_s;
      count     = count_r;
   end

   // Fetch PC, request PC and in-flight tracking; redirect overrides everything.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_r <= PC_RESET;
         req_pc_r   <= 32'h0000_0000;
         inflight_r <= 1'b0;
      end else if (redirect) begin
         fetch_pc_r <= redirect_pc & ~32'h0000_0003;
         inflight_r <= 1'b0;
      end else begin
         if (issue_s) begin
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 32'h0000_0004;
         end
         inflight_r <= issue_s;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (redirect) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage: instruction word tagged with the PC it was fetched from.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_r[i] <= 32'h0000_0000;
            pc_mem_r[i]   <= 32'h0000_0000;
         end
      end else if (push_s) begin
         inst_mem_r[wr_ptr_r] <= imem_data;
         pc_mem_r[wr_ptr_r]   <= req_pc_r;
      end
   end

endmodule
